// File: rtl/regbank_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : regbank_burst_master
// Purpose  : Burst initiator that drives a 16x8 register bank one beat at a time
// Revision : 1.0 - initial release
// ============================================================================
module regbank_burst_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_CAPT  = 3'd3,
    S_RD_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  C_LEN_ONE  = LEN_W'(1);

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]  r_rdata, w_rdata_nxt;
  logic               r_rf_wr_en, w_rf_wr_en_nxt;
  logic               r_rf_rd_en, w_rf_rd_en_nxt;
  logic [ADDR_W-1:0]  r_rf_addr, w_rf_addr_nxt;
  logic [DATA_W-1:0]  r_rf_data_in, w_rf_data_in_nxt;
  logic [ADDR_W-1:0]  w_addr_inc;
  logic               w_last;

  assign w_addr_inc = r_addr + C_ADDR_ONE;
  assign w_last     = (r_cnt == '0);

  // Strobes are registered on entry to the beat, so a read strobe is armed
  // together with the transition into S_RD_ISSUE.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_cnt_nxt        = r_cnt;
    w_rdata_nxt      = r_rdata;
    w_rf_wr_en_nxt   = 1'b0;
    w_rf_rd_en_nxt   = 1'b0;
    w_rf_addr_nxt    = r_rf_addr;
    w_rf_data_in_nxt = r_rf_data_in;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_addr_nxt = cmd_addr;
          w_cnt_nxt  = cmd_len;
          if (cmd_write) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt    = S_RD_ISSUE;
            w_rf_rd_en_nxt = 1'b1;
            w_rf_addr_nxt  = cmd_addr;
          end
        end
      end
      S_WR: begin
        if (wdata_valid) begin
          w_rf_wr_en_nxt   = 1'b1;
          w_rf_addr_nxt    = r_addr;
          w_rf_data_in_nxt = wdata;
          w_addr_nxt       = w_addr_inc;
          w_cnt_nxt        = r_cnt - C_LEN_ONE;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RD_ISSUE: begin
        w_state_nxt = S_RD_CAPT;
      end
      S_RD_CAPT: begin
        w_rdata_nxt = rf_data_out;
        w_state_nxt = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (rready) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt    = S_RD_ISSUE;
            w_rf_rd_en_nxt = 1'b1;
            w_rf_addr_nxt  = w_addr_inc;
            w_addr_nxt     = w_addr_inc;
            w_cnt_nxt      = r_cnt - C_LEN_ONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_rd_en   <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_data_in <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rdata      <= w_rdata_nxt;
      r_rf_wr_en   <= w_rf_wr_en_nxt;
      r_rf_rd_en   <= w_rf_rd_en_nxt;
      r_rf_addr    <= w_rf_addr_nxt;
      r_rf_data_in <= w_rf_data_in_nxt;
    end
  end

  // cmd_ready is masked while reset is held so every output reads 0 during reset.
  assign cmd_ready   = (r_state == S_IDLE) && !reset;
  assign wdata_ready = (r_state == S_WR);
  assign rvalid      = (r_state == S_RD_HOLD);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign rdata       = r_rdata;
  assign rf_wr_en    = r_rf_wr_en;
  assign rf_rd_en    = r_rf_rd_en;
  assign rf_addr     = r_rf_addr;
  assign rf_data_in  = r_rf_data_in;

endmodule
`default_nettype wire

// File: tb/tb_regbank_burst_master.sv
`default_nettype none
// Bench for regbank_burst_master: behavioural 16x8 bank, reference memory model
// and strobe scoreboard; randomized data, gaps and stalls.
module tb_regbank_burst_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rvalid, rready;
  logic [7:0] rdata;
  logic       busy, done, rf_wr_en, rf_rd_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_data_in, rf_data_out;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  logic [11:0] exp_wq[$];
  logic [3:0]  exp_rq[$];
  logic [7:0]  ref_mem[16];
  logic [7:0]  mem[16];
  logic [7:0]  bank_q;
  bit          bank_init;
  logic [11:0] mon_w;
  logic [3:0]  mon_r;

  always #5 clk = ~clk;

  regbank_burst_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .busy(busy), .done(done),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  // Register bank: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      bank_init <= 1'b1;
    end else begin
      if (rf_wr_en) mem[rf_addr] <= rf_data_in;
      if (rf_rd_en) bank_q <= mem[rf_addr];
    end
  end
  assign rf_data_out = bank_q;

  // Strobe scoreboard: every strobe must match the next expected beat.
  always @(negedge clk) begin
    if (rf_wr_en || rf_rd_en) begin
      checks++;
      if (rf_wr_en && rf_rd_en) begin
        errors++;
        $display("FAIL strobe_onehot wr=%0b rd=%0b required at most one", rf_wr_en, rf_rd_en);
      end
    end
    if (rf_wr_en) begin
      wr_cnt++;
      checks++;
      if (exp_wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wr addr=%0h data=%0h required no strobe", rf_addr, rf_data_in);
      end else begin
        mon_w = exp_wq.pop_front();
        if ({rf_addr, rf_data_in} !== mon_w) begin
          errors++;
          $display("FAIL wr_beat got addr=%0h data=%0h required addr=%0h data=%0h",
                   rf_addr, rf_data_in, mon_w[11:8], mon_w[7:0]);
        end
      end
    end
    if (rf_rd_en) begin
      rd_cnt++;
      checks++;
      if (exp_rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd addr=%0h required no strobe", rf_addr);
      end else begin
        mon_r = exp_rq.pop_front();
        if (rf_addr !== mon_r) begin
          errors++;
          $display("FAIL rd_addr got %0h required %0h", rf_addr, mon_r);
        end
      end
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic issue_cmd(input bit wr, input logic [3:0] a, input logic [3:0] l);
    int n;
    cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    #1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL cmd_timeout got cmd_ready=0 required 1 within 100 cycles");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drive_beats(input logic [3:0] a, input logic [3:0] l,
                             input logic [7:0] d[16], input int gmax);
    int n;
    logic [3:0] ad;
    for (int i = 0; i <= int'(l); i++) begin
      wdata_valid = 1'b0;
      repeat ($urandom_range(0, gmax)) @(negedge clk);
      wdata_valid = 1'b1;
      wdata = d[i];
      n = 0;
      while (!wdata_ready && n < 50) begin
        @(negedge clk); n++;
      end
      if (n >= 50) begin
        checks++; errors++;
        $display("FAIL wdata_timeout got wdata_ready=0 required 1");
        wdata_valid = 1'b0;
        return;
      end
      ad = a + 4'(i);
      exp_wq.push_back({ad, d[i]});
      ref_mem[ad] = d[i];
      @(negedge clk);
    end
    wdata_valid = 1'b0;
  endtask

  task automatic run_write(input logic [3:0] a, input logic [3:0] l,
                           input logic [7:0] d[16], input int gmax);
    issue_cmd(1'b1, a, l);
    drive_beats(a, l, d, gmax);
  endtask

  task automatic collect_read(input logic [3:0] l, input int smax,
                              output logic [7:0] got[16], output int lat);
    int n;
    lat = -1;
    for (int i = 0; i < 16; i++) got[i] = 8'hxx;
    for (int i = 0; i <= int'(l); i++) begin
      n = 0;
      while (!rvalid && n < 20) begin
        @(negedge clk); n++;
      end
      if (n >= 20) begin
        checks++; errors++;
        $display("FAIL rvalid_timeout got rvalid=0 required 1");
        return;
      end
      if (i == 0) lat = n;
      repeat ($urandom_range(0, smax)) @(negedge clk);
      rready = 1'b1;
      got[i] = rdata;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  task automatic run_read(input logic [3:0] a, input logic [3:0] l, input int smax,
                          output logic [7:0] got[16], output int lat);
    for (int i = 0; i <= int'(l); i++) exp_rq.push_back(a + 4'(i));
    issue_cmd(1'b0, a, l);
    collect_read(l, smax, got, lat);
  endtask

  task automatic test_reset;
    checks++;
    if ({cmd_ready, wdata_ready, rvalid, busy, done, rf_wr_en, rf_rd_en, rf_addr, rf_data_in, rdata} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got cmd_ready=%0b busy=%0b rf_wr=%0b rf_rd=%0b rdata=%0h required all 0",
               cmd_ready, busy, rf_wr_en, rf_rd_en, rdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got cmd_ready=%0b busy=%0b required 1 0", cmd_ready, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_single_write;
    int wc0, dc0;
    wc0 = wr_cnt; dc0 = done_cnt;
    issue_cmd(1'b1, 4'h2, 4'h0);
    wdata_valid = 1'b1; wdata = 8'hA5;
    checks++;
    if (wdata_ready !== 1'b1 || rf_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_wr_ready got wdata_ready=%0b rf_wr_en=%0b required 1 0", wdata_ready, rf_wr_en);
    end
    exp_wq.push_back({4'h2, 8'hA5});
    ref_mem[2] = 8'hA5;
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    checks++;
    if ({rf_wr_en, rf_addr, rf_data_in, done} !== {1'b1, 4'h2, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL single_wr_strobe got en=%0b addr=%0h data=%0h done=%0b required 1 2 a5 1",
               rf_wr_en, rf_addr, rf_data_in, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || rf_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_wr_after got done=%0b cmd_ready=%0b rf_wr_en=%0b required 0 1 0", done, cmd_ready, rf_wr_en);
    end
    checks++;
    if (wr_cnt - wc0 !== 1 || done_cnt - dc0 !== 1) begin
      errors++;
      $display("FAIL single_wr_counts got wr=%0d done=%0d required 1 1", wr_cnt - wc0, done_cnt - dc0);
    end
  endtask

  task automatic test_wrap_gaps;
    logic [7:0] d[16];
    logic [7:0] got[16];
    logic [7:0] ex[4];
    int lat;
    ex[0] = 8'h11; ex[1] = 8'h22; ex[2] = 8'h33; ex[3] = 8'h44;
    for (int i = 0; i < 16; i++) d[i] = (i < 4) ? ex[i] : 8'h00;
    run_write(4'hE, 4'h3, d, 3);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_wr_done got %0b required 1", done);
    end
    @(negedge clk);
    run_read(4'hE, 4'h3, 0, got, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL rd_latency got %0d required 2 cycles after rf_rd_en", lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== ex[i]) begin
        errors++;
        $display("FAIL wrap_rd_beat%0d got %0h required %0h", i, got[i], ex[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_read_stall;
    int rc0, n;
    logic [7:0] v;
    rc0 = rd_cnt;
    exp_rq.push_back(4'hE);
    exp_rq.push_back(4'hF);
    issue_cmd(1'b0, 4'hE, 4'h1);
    checks++;
    if (rf_rd_en !== 1'b1 || rf_addr !== 4'hE) begin
      errors++;
      $display("FAIL stall_issue got rf_rd_en=%0b addr=%0h required 1 e", rf_rd_en, rf_addr);
    end
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    v = rdata;
    checks++;
    if (v !== 8'h11) begin
      errors++;
      $display("FAIL stall_beat0 got %0h required 11", v);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== v) begin
        errors++;
        $display("FAIL stall_hold%0d got rvalid=%0b rdata=%0h required 1 %0h", i, rvalid, rdata, v);
      end
    end
    checks++;
    if (rd_cnt - rc0 !== 1) begin
      errors++;
      $display("FAIL stall_no_reissue got %0d strobes required 1", rd_cnt - rc0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rdata !== 8'h22) begin
      errors++;
      $display("FAIL stall_beat1 got %0h required 22", rdata);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checks++;
    if (done !== 1'b1 || rd_cnt - rc0 !== 2) begin
      errors++;
      $display("FAIL stall_end got done=%0b strobes=%0d required 1 2", done, rd_cnt - rc0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d[2];
    logic [7:0] got[16];
    int lat;
    d[0] = 8'($urandom); d[1] = 8'($urandom);
    issue_cmd(1'b1, 4'h5, 4'h1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5; cmd_len = 4'h1;
    exp_rq.push_back(4'h5);
    exp_rq.push_back(4'h6);
    for (int i = 0; i < 2; i++) begin
      wdata_valid = 1'b1; wdata = d[i];
      checks++;
      if (cmd_ready !== 1'b0 || wdata_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_wr%0d got cmd_ready=%0b wdata_ready=%0b required 0 1", i, cmd_ready, wdata_ready);
      end
      exp_wq.push_back({4'h5 + 4'(i), d[i]});
      ref_mem[4'h5 + 4'(i)] = d[i];
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done got done=%0b cmd_ready=%0b required 1 0", done, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rf_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got cmd_ready=%0b rf_rd_en=%0b required 1 0", cmd_ready, rf_rd_en);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (rf_rd_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got rf_rd_en=%0b busy=%0b required 1 1", rf_rd_en, busy);
    end
    collect_read(4'h1, 2, got, lat);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got[i] !== d[i]) begin
        errors++;
        $display("FAIL b2b_rd%0d got %0h required %0h", i, got[i], d[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midburst;
    logic [7:0] d[16];
    logic [7:0] got[16];
    int dc0, lat;
    for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
    dc0 = done_cnt;
    issue_cmd(1'b1, 4'h8, 4'h7);
    for (int i = 0; i < 2; i++) begin
      wdata_valid = 1'b1; wdata = d[i];
      exp_wq.push_back({4'h8 + 4'(i), d[i]});
      ref_mem[4'h8 + 4'(i)] = d[i];
      @(negedge clk);
    end
    wdata = d[2];
    reset = 1'b1;
    @(negedge clk);
    wdata_valid = 1'b0;
    checks++;
    if ({cmd_ready, wdata_ready, rvalid, busy, done, rf_wr_en, rf_rd_en, rf_addr, rf_data_in, rdata} !== 27'd0) begin
      errors++;
      $display("FAIL midrst_outputs got busy=%0b wdata_ready=%0b rf_wr=%0b addr=%0h required all 0",
               busy, wdata_ready, rf_wr_en, rf_addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle got cmd_ready=%0b busy=%0b required 1 0", cmd_ready, busy);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_cnt !== dc0 || exp_wq.size() !== 0) begin
      errors++;
      $display("FAIL midrst_abandon got done_pulses=%0d pending=%0d required 0 0", done_cnt - dc0, exp_wq.size());
    end
    run_read(4'h8, 4'h7, 1, got, lat);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== ref_mem[4'h8 + 4'(i)]) begin
        errors++;
        $display("FAIL midrst_rd%0d got %0h required %0h", i, got[i], ref_mem[4'h8 + 4'(i)]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_full_bank;
    logic [7:0] d[16];
    logic [7:0] got[16];
    int wc0, rc0, lat;
    for (int i = 0; i < 16; i++) d[i] = 8'(i);
    wc0 = wr_cnt; rc0 = rd_cnt;
    run_write(4'h0, 4'hF, d, 0);
    @(negedge clk);
    run_read(4'h0, 4'hF, 0, got, lat);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 8'(i)) begin
        errors++;
        $display("FAIL full_rd%0d got %0h required %0h", i, got[i], i);
      end
    end
    @(negedge clk);
    checks++;
    if (wr_cnt - wc0 !== 16 || rd_cnt - rc0 !== 16) begin
      errors++;
      $display("FAIL full_counts got wr=%0d rd=%0d required 16 16", wr_cnt - wc0, rd_cnt - rc0);
    end
  endtask

  task automatic test_random;
    logic [7:0] d[16];
    logic [7:0] got[16];
    logic [3:0] a, l;
    int lat;
    for (int it = 0; it < 12; it++) begin
      a = 4'($urandom); l = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
        run_write(a, l, d, 2);
      end else begin
        run_read(a, l, 3, got, lat);
        for (int i = 0; i <= int'(l); i++) begin
          checks++;
          if (got[i] !== ref_mem[a + 4'(i)]) begin
            errors++;
            $display("FAIL rand%0d_rd%0d got %0h required %0h", it, i, got[i], ref_mem[a + 4'(i)]);
          end
        end
      end
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_done got %0b required 1", it, done);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    test_reset;
    test_single_write;
    test_wrap_gaps;
    test_read_stall;
    test_back_to_back;
    test_reset_midburst;
    test_full_bank;
    test_random;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_wq.size() !== 0 || exp_rq.size() !== 0) begin
      errors++;
      $display("FAIL leftover_beats got wr=%0d rd=%0d required 0 0", exp_wq.size(), exp_rq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
